// File: rtl/reg_pkg.sv
// Shared types and next-value function for the register bank.
// reg_next works on a RegMaxWidth-bit word; callers zero-extend operands and truncate the
// result back to WIDTH, which keeps INC/DEC modulo 2^WIDTH for any WIDTH <= RegMaxWidth.
package reg_pkg;

  typedef enum logic [2:0] {
    REG_OP_NONE  = 3'd0,
    REG_OP_LOAD  = 3'd1,
    REG_OP_INC   = 3'd2,
    REG_OP_DEC   = 3'd3,
    REG_OP_CLEAR = 3'd4
  } reg_op_t;

  localparam int unsigned RegMaxWidth = 64;

  typedef logic [RegMaxWidth-1:0] reg_word_t;

  function automatic reg_word_t reg_next(reg_op_t op, reg_word_t cur, reg_word_t bus_in);
    reg_word_t res;
    case (op)
      REG_OP_LOAD:  res = bus_in;
      REG_OP_INC:   res = cur + reg_word_t'(1);
      REG_OP_DEC:   res = cur - reg_word_t'(1);
      REG_OP_CLEAR: res = '0;
      default:      res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_bank_ctx_if.sv
// Decoder/ALU-side port bundle of the register bank with its context-stack status.
// master drives op/address/save/restore, slave is the bank.
interface register_bank_ctx_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREGS     = 4,
  parameter int unsigned CTX_DEPTH = 2
);
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned LW = $clog2(CTX_DEPTH + 1);

  logic [AW-1:0]     addr_w;
  reg_pkg::reg_op_t  op;
  logic [WIDTH-1:0]  bus_in;
  logic [AW-1:0]     addr_a;
  logic [WIDTH-1:0]  rd_a;
  logic [AW-1:0]     addr_b;
  logic [WIDTH-1:0]  rd_b;
  logic              save;
  logic              restore;
  logic [LW-1:0]     ctx_level;
  logic              ctx_full;
  logic              ctx_empty;
  logic              ctx_err;

  modport master (
    output addr_w, op, bus_in, addr_a, addr_b, save, restore,
    input  rd_a, rd_b, ctx_level, ctx_full, ctx_empty, ctx_err
  );

  modport slave (
    input  addr_w, op, bus_in, addr_a, addr_b, save, restore,
    output rd_a, rd_b, ctx_level, ctx_full, ctx_empty, ctx_err
  );

endinterface

// File: rtl/reg_ctx_stack.sv
// Context stack: CTX_DEPTH snapshots of the whole bank, occupancy counter, full/empty and a
// registered one-cycle error pulse for illegal save/restore requests.
module reg_ctx_stack #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREGS     = 4,
  parameter int unsigned CTX_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          save_i,
  input  logic                          restore_i,
  input  logic [NREGS*WIDTH-1:0]        snap_i,
  output logic [NREGS*WIDTH-1:0]        snap_o,
  output logic                          pop_ok_o,
  output logic [$clog2(CTX_DEPTH+1)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o
);
  localparam int unsigned SnapW = NREGS * WIDTH;
  localparam int unsigned LW    = $clog2(CTX_DEPTH + 1);

  logic [SnapW-1:0] slot_q [CTX_DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic             err_q, err_d;
  logic             full, empty, push_ok, pop_ok;

  // Legality of the request and next occupancy; illegal requests leave the stack untouched.
  always_comb begin
    full    = (level_q == LW'(CTX_DEPTH));
    empty   = (level_q == '0);
    push_ok = save_i & ~restore_i & ~full;
    pop_ok  = restore_i & ~save_i & ~empty;
    err_d   = (save_i & restore_i) | (save_i & full) | (restore_i & empty);
    level_d = level_q;
    if (push_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  // Occupancy and error pulse; reset discards every stacked context.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Slot storage needs no reset: a slot is only read after it has been pushed.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < CTX_DEPTH; i++) begin
      if (push_ok && level_q == LW'(i)) begin
        slot_q[i] <= snap_i;
      end
    end
  end

  // Top-of-stack read (slot level-1) for the bank's restore mux.
  always_comb begin
    snap_o = '0;
    for (int unsigned i = 0; i < CTX_DEPTH; i++) begin
      if (level_q == LW'(i + 1)) begin
        snap_o = slot_q[i];
      end
    end
  end

  assign pop_ok_o = pop_ok;
  assign level_o  = level_q;
  assign full_o   = full;
  assign empty_o  = empty;
  assign err_o    = err_q;

endmodule

// File: rtl/register_bank_ctx.sv
// Register bank: NREGS x WIDTH live registers, one op/write port, two combinational read ports
// and a CTX_DEPTH-deep snapshot stack. A legal restore overrides any same-cycle op.
// Optional feature: define REG_BANK_BYPASS_EN for write-through forwarding on the read ports.
module register_bank_ctx
  import reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREGS     = 4,
  parameter int unsigned CTX_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  register_bank_ctx_if.slave bus
);
  localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned SnapW = NREGS * WIDTH;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [SnapW-1:0] snap, snap_rd;
  logic [WIDTH-1:0] cur_w, wr_val;
  logic             pop_ok;
`ifdef REG_BANK_BYPASS_EN
  logic             wr_hit;
`endif

  // Flatten the bank for the stack and compute the op result for the addressed register.
  always_comb begin
    snap  = '0;
    cur_w = '0;
`ifdef REG_BANK_BYPASS_EN
    wr_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < NREGS; i++) begin
      snap[i*WIDTH +: WIDTH] = regs_q[i];
      if (bus.addr_w == AW'(i)) begin
        cur_w = regs_q[i];
`ifdef REG_BANK_BYPASS_EN
        wr_hit = 1'b1;
`endif
      end
    end
    wr_val = WIDTH'(reg_next(bus.op, reg_word_t'(cur_w), reg_word_t'(bus.bus_in)));
  end

  // Next bank state: restore data wins, otherwise apply the op to an in-range addr_w.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (pop_ok) begin
        regs_d[i] = snap_rd[i*WIDTH +: WIDTH];
      end else if (bus.op != REG_OP_NONE && bus.addr_w == AW'(i)) begin
        regs_d[i] = wr_val;
      end
    end
  end

  // Live registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; out-of-range addresses read as zero.
  always_comb begin
    bus.rd_a = '0;
    bus.rd_b = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (bus.addr_a == AW'(i)) bus.rd_a = regs_q[i];
      if (bus.addr_b == AW'(i)) bus.rd_b = regs_q[i];
    end
`ifdef REG_BANK_BYPASS_EN
    if (bus.op != REG_OP_NONE && !bus.restore && wr_hit) begin
      if (bus.addr_a == bus.addr_w) bus.rd_a = wr_val;
      if (bus.addr_b == bus.addr_w) bus.rd_b = wr_val;
    end
`endif
  end

  reg_ctx_stack #(
    .WIDTH     (WIDTH),
    .NREGS     (NREGS),
    .CTX_DEPTH (CTX_DEPTH)
  ) u_stack (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .save_i    (bus.save),
    .restore_i (bus.restore),
    .snap_i    (snap),
    .snap_o    (snap_rd),
    .pop_ok_o  (pop_ok),
    .level_o   (bus.ctx_level),
    .full_o    (bus.ctx_full),
    .empty_o   (bus.ctx_empty),
    .err_o     (bus.ctx_err)
  );

endmodule
